// File: rtl/fifo_periph.sv
// Memory-mapped 32-bit FIFO peripheral: DATA push/pop, STATUS occupancy, CTRL enable/clear, level irq.
// Optional sticky overflow/underflow flags in STATUS[3:2]: define FIFO_PERIPH_ERR_FLAGS_EN.
module fifo_periph #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busSel,
    input  logic        busRe,
    input  logic [1:0]  busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        irq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_CTRL, REG_RSVD} reg_e;
    typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_e;

    function automatic occ_e occ_of(input logic [AW:0] c);
        if (c == '0)
            return OCC_EMPTY;
        else if (c == FULL_CNT)
            return OCC_FULL;
        else
            return OCC_PARTIAL;
    endfunction

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wrptr, rdptr;
    logic [AW:0]   count, count_nxt;
    logic          irqEn, irqEn_nxt, irq_nxt;
    occ_e          occ;
    reg_e          regsel;
    logic          wr, rd, push, pop, clr, empty, full;
    logic          unused_addr_bits;
`ifdef FIFO_PERIPH_ERR_FLAGS_EN
    logic          ovf, udf, ovf_nxt, udf_nxt;
`endif

    assign unused_addr_bits = ^{busAddr[31:4], busAddr[1:0]};

    always_comb begin
        regsel = reg_e'(busAddr[3:2]);
        occ    = occ_of(count);
        empty  = (occ == OCC_EMPTY);
        full   = (occ == OCC_FULL);
        // A store claims the cycle; busRe is only honoured when no write strobe is present.
        wr     = busSel && (busWe != 2'b00);
        rd     = busSel && busRe && !wr;
        push   = wr && (regsel == REG_DATA) && !full;
        pop    = rd && (regsel == REG_DATA) && !empty;
        clr    = wr && (regsel == REG_CTRL) && busWData[1];
    end

    always_comb begin
        count_nxt = count;
        irqEn_nxt = irqEn;
        if (clr)
            count_nxt = '0;
        else if (push)
            count_nxt = count + 1'b1;
        else if (pop)
            count_nxt = count - 1'b1;
        if (wr && (regsel == REG_CTRL))
            irqEn_nxt = busWData[0];
`ifdef FIFO_PERIPH_ERR_FLAGS_EN
        ovf_nxt = ovf;
        udf_nxt = udf;
        if (clr) begin
            ovf_nxt = 1'b0;
            udf_nxt = 1'b0;
        end else begin
            if (wr && (regsel == REG_STATUS)) begin
                if (busWData[2]) ovf_nxt = 1'b0;
                if (busWData[3]) udf_nxt = 1'b0;
            end
            if (wr && (regsel == REG_DATA) && full)  ovf_nxt = 1'b1;
            if (rd && (regsel == REG_DATA) && empty) udf_nxt = 1'b1;
        end
        irq_nxt = irqEn_nxt && ((occ_of(count_nxt) != OCC_EMPTY) || ovf_nxt || udf_nxt);
`else
        irq_nxt = irqEn_nxt && (occ_of(count_nxt) != OCC_EMPTY);
`endif
    end

    // irq is registered from next-state so it follows the triggering access by exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrptr <= '0;
            rdptr <= '0;
            count <= '0;
            irqEn <= 1'b0;
            irq   <= 1'b0;
`ifdef FIFO_PERIPH_ERR_FLAGS_EN
            ovf   <= 1'b0;
            udf   <= 1'b0;
`endif
        end else begin
            count <= count_nxt;
            irqEn <= irqEn_nxt;
            irq   <= irq_nxt;
`ifdef FIFO_PERIPH_ERR_FLAGS_EN
            ovf   <= ovf_nxt;
            udf   <= udf_nxt;
`endif
            if (clr) begin
                wrptr <= '0;
                rdptr <= '0;
            end else begin
                if (push) wrptr <= wrptr + 1'b1;
                if (pop)  rdptr <= rdptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wrptr] <= busWData;
    end

    always_comb begin
        busRData = '0;
        if (busSel) begin
            case (regsel)
                REG_DATA: begin
                    if (!empty) busRData = mem[rdptr];
                end
                REG_STATUS: begin
                    busRData[0]        = empty;
                    busRData[1]        = full;
                    busRData[8 +: AW+1] = count;
`ifdef FIFO_PERIPH_ERR_FLAGS_EN
                    busRData[2]        = ovf;
                    busRData[3]        = udf;
`endif
                end
                REG_CTRL: busRData[0] = irqEn;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_periph.sv
// Bench for fifo_periph: queue-based reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_fifo_periph;
    localparam int DEPTH = 8;
    localparam logic [31:0] A_DATA   = 32'h1000_0040;
    localparam logic [31:0] A_STATUS = 32'h1000_0044;
    localparam logic [31:0] A_CTRL   = 32'h1000_0048;
    localparam logic [31:0] A_RSVD   = 32'h1000_004C;
`ifdef FIFO_PERIPH_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        busSel, busRe;
    logic [1:0]  busWe;
    logic [31:0] busAddr, busWData, busRData;
    logic        irq;

    int tests = 0;
    int fails = 0;

    fifo_periph #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .busSel(busSel), .busRe(busRe), .busWe(busWe),
        .busAddr(busAddr), .busWData(busWData), .busRData(busRData), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: queue of stored words plus enable and sticky flags.
    logic [31:0] q[$];
    bit m_en, m_irq, m_ovf, m_udf, started;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_en = 0; m_ovf = 0; m_udf = 0;
        end else if (busSel) begin
            if (busWe != 2'b00) begin
                case (busAddr[3:2])
                    2'd0: if (q.size() < DEPTH) q.push_back(busWData); else m_ovf = FLAGS;
                    2'd1: if (FLAGS) begin
                        if (busWData[2]) m_ovf = 0;
                        if (busWData[3]) m_udf = 0;
                    end
                    2'd2: begin
                        m_en = busWData[0];
                        if (busWData[1]) begin q.delete(); m_ovf = 0; m_udf = 0; end
                    end
                    default: ;
                endcase
            end else if (busRe && busAddr[3:2] == 2'd0) begin
                if (q.size() > 0) void'(q.pop_front()); else m_udf = FLAGS;
            end
        end
        m_irq = !reset && m_en && (q.size() != 0 || m_ovf || m_udf);
    end

    function automatic logic [31:0] model_rdata();
        logic [31:0] r = '0;
        if (!busSel) return r;
        case (busAddr[3:2])
            2'd0: if (q.size() > 0) r = q[0];
            2'd1: begin
                r[0]    = (q.size() == 0);
                r[1]    = (q.size() == DEPTH);
                r[2]    = m_ovf;
                r[3]    = m_udf;
                r[16:8] = 9'(q.size());
            end
            2'd2: r[0] = m_en;
            default: ;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            check("irq_model", {31'b0, irq}, {31'b0, m_irq});
            if (!busSel || busRe) check("rdata_model", busRData, model_rdata());
        end
    end

    task automatic drive(input logic sel, input logic re, input logic [1:0] we,
                         input logic [31:0] addr, input logic [31:0] data);
        busSel = sel; busRe = re; busWe = we; busAddr = addr; busWData = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)),
              addr | 32'($urandom_range(0, 3)), data);
        step();
    endtask

    task automatic rd(input string nm, input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b1, 1'b1, 2'b00, addr | 32'($urandom_range(0, 3)), $urandom);
        @(negedge clk);
        check(nm, busRData, exp);
        step();
    endtask

    task automatic check_irq(input string nm, input logic exp);
        drive(1'b0, 1'b0, 2'b00, '0, '0);
        @(negedge clk);
        check(nm, {31'b0, irq}, {31'b0, exp});
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, '0, '0);
        step(); step();
        reset = 1'b0;
        started = 1'b1;

        rd("reset_status", A_STATUS, 32'h0000_0001);
        check_irq("reset_irq", 1'b0);
        rd("reset_ctrl", A_CTRL, 32'h0);

        wr(A_DATA, 32'h11); wr(A_DATA, 32'h22); wr(A_DATA, 32'h33);
        check("model_cnt3", 32'(q.size()), 32'd3);
        rd("pop_11", A_DATA, 32'h11);
        rd("pop_22", A_DATA, 32'h22);
        rd("pop_33", A_DATA, 32'h33);
        rd("status_after3", A_STATUS, 32'h0000_0001);

        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 8; i++) wr(A_DATA, 32'hA0 + 32'(i));
            rd("status_full", A_STATUS, 32'h0000_0802);
            wr(A_DATA, 32'hA8);
            rd("status_ovf", A_STATUS, 32'h0000_0802 | (FLAGS ? 32'h4 : 32'h0));
            for (int i = 0; i < 8; i++) rd("pop_wrap", A_DATA, 32'hA0 + 32'(i));
            rd("status_drain", A_STATUS, 32'h0000_0001 | (FLAGS ? 32'h4 : 32'h0));
            wr(A_STATUS, 32'h4);
        end

        rd("empty_read", A_DATA, 32'h0);
        rd("status_udf", A_STATUS, FLAGS ? 32'h0000_0009 : 32'h0000_0001);
        wr(A_STATUS, 32'h8);
        rd("status_udf_clr", A_STATUS, 32'h0000_0001);

        wr(A_CTRL, 32'h1);
        check_irq("irq_en_empty", 1'b0);
        wr(A_DATA, 32'h55);
        check_irq("irq_rise", 1'b1);
        rd("pop_55", A_DATA, 32'h55);
        check_irq("irq_fall", 1'b0);
        for (int i = 0; i < 4; i++) wr(A_DATA, 32'hC0 + 32'(i));
        rd("status_cnt4", A_STATUS, 32'h0000_0400);
        wr(A_CTRL, 32'h3);
        rd("status_clr", A_STATUS, 32'h0000_0001);
        check_irq("irq_clr", 1'b0);
        rd("ctrl_en", A_CTRL, 32'h1);

        for (int i = 0; i < 5; i++) wr(A_DATA, 32'hD0 + 32'(i));
        check("model_cnt5", 32'(q.size()), 32'd5);
        reset = 1'b1;
        drive(1'b1, 1'b0, 2'b01, A_DATA, 32'hDEAD_BEEF);
        step();
        reset = 1'b0;
        check_irq("irq_after_reset", 1'b0);
        rd("status_after_reset", A_STATUS, 32'h0000_0001);
        rd("ctrl_after_reset", A_CTRL, 32'h0);

        drive(1'b1, 1'b1, 2'b10, A_DATA, 32'h77);
        step();
        rd("wr_priority", A_DATA, 32'h77);
        drive(1'b0, 1'b1, 2'b01, A_DATA, 32'h99);
        @(negedge clk);
        check("nosel_rdata", busRData, 32'h0);
        step();
        wr(A_RSVD, 32'hFFFF_FFFF);
        rd("rsvd_read", A_RSVD, 32'h0);
        rd("status_final", A_STATUS, 32'h0000_0001);
        rd("ctrl_final", A_CTRL, 32'h0);

        drive(1'b0, 1'b0, 2'b00, '0, '0);
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
